// File: rtl/uart_tx_fifo.sv
// Byte queue between the CPU bus and uart_tx: the CPU pushes bytes and a feeder FSM strobes them
// into uart_tx one per frame. Define UART_TXQ_IRQ_EN to build the queue-drained interrupt pulse.
module uart_tx_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [7:0] i_dat,
   output logic [7:0] o_dat,
   input  logic       i_we,
   input  logic       i_cyc,
   output logic [7:0] o_tx_dat,
   output logic       o_tx_we,
   output logic       o_tx_cyc,
   input  logic       i_tx_busy,
   output logic       o_int
);

   typedef enum logic [1:0] {StIdle, StIssue, StAck, StDrain} state_e;

   localparam logic [AW:0]   FullCount = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CountOne  = (AW+1)'(1);
   localparam logic [AW-1:0] PtrOne    = AW'(1);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   count_q, count_d;
   logic          ovf_q, ovf_d;

   logic          full, empty;
   logic          push, push_drop, pop, status_rd;
   logic [4:0]    count_ext;

   state_e        state_q;
   logic [1:0]    ack_cnt_q;
   logic          tx_cyc_q, tx_we_q;
   logic [7:0]    tx_dat_q;

   assign full      = (count_q == FullCount);
   assign empty     = (count_q == '0);
   // full is taken from the registered count, so a pop in the same cycle cannot make room
   assign push      = i_cyc & i_we & ~full;
   assign push_drop = i_cyc & i_we & full;
   assign status_rd = i_cyc & ~i_we;
   assign pop       = (state_q == StIssue);

   assign count_ext = 5'(count_q);
   assign o_dat     = {full, empty, ovf_q, count_ext};

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      if (push) begin
         wptr_d = wptr_q + PtrOne;
      end
      if (pop) begin
         rptr_d = rptr_q + PtrOne;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CountOne;
         2'b01:   count_d = count_q - CountOne;
         default: count_d = count_q;
      endcase
      if (push_drop) begin
         ovf_d = 1'b1;
      end else if (status_rd) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) begin
         mem_q[wptr_q] <= i_dat;
      end
   end

   // Feeder: strobe in ISSUE, then wait for uart_tx to take and finish the frame.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= StIdle;
         ack_cnt_q <= '0;
         tx_cyc_q  <= 1'b0;
         tx_we_q   <= 1'b0;
         tx_dat_q  <= '0;
      end else begin
         tx_cyc_q <= 1'b0;
         tx_we_q  <= 1'b0;
         tx_dat_q <= '0;
         unique case (state_q)
            StIdle: begin
               if (!empty && !i_tx_busy) begin
                  state_q  <= StIssue;
                  tx_cyc_q <= 1'b1;
                  tx_we_q  <= 1'b1;
                  tx_dat_q <= mem_q[rptr_q];
               end
            end
            StIssue: begin
               state_q   <= StAck;
               ack_cnt_q <= '0;
            end
            StAck: begin
               if (i_tx_busy) begin
                  state_q <= StDrain;
               end else if (ack_cnt_q == 2'd3) begin
                  // uart_tx never acknowledged; treat the byte as sent
                  state_q <= StIdle;
               end else begin
                  ack_cnt_q <= ack_cnt_q + 2'd1;
               end
            end
            StDrain: begin
               if (!i_tx_busy) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign o_tx_cyc = tx_cyc_q;
   assign o_tx_we  = tx_we_q;
   assign o_tx_dat = tx_dat_q;

`ifdef UART_TXQ_IRQ_EN
   logic int_q;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         int_q <= 1'b0;
      end else begin
         int_q <= (state_q == StDrain) && !i_tx_busy && empty && !push;
      end
   end

   assign o_int = int_q;
`else
   assign o_int = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based reference model plus a behavioural uart_tx responder.
module tb_uart_tx_fifo;

   localparam int DEPTH = 16;
`ifdef UART_TXQ_IRQ_EN
   localparam int ExpPulses = 1;
`else
   localparam int ExpPulses = 0;
`endif

   logic       clk = 1'b0;
   logic       i_reset_n = 1'b0;
   logic [7:0] i_dat = '0;
   logic       i_we = 1'b0;
   logic       i_cyc = 1'b0;
   logic       i_tx_busy = 1'b0;
   logic [7:0] o_dat, o_tx_dat;
   logic       o_tx_we, o_tx_cyc, o_int;

   always #5 clk = ~clk;

   uart_tx_fifo #(.DEPTH(DEPTH), .AW(4)) dut (
      .i_clk     (clk),
      .i_reset_n (i_reset_n),
      .i_dat     (i_dat),
      .o_dat     (o_dat),
      .i_we      (i_we),
      .i_cyc     (i_cyc),
      .o_tx_dat  (o_tx_dat),
      .o_tx_we   (o_tx_we),
      .o_tx_cyc  (o_tx_cyc),
      .i_tx_busy (i_tx_busy),
      .o_int     (o_int)
   );

   int nvec = 0;
   int nerr = 0;

   // Reference model: queue contents and sticky overflow flag
   logic [7:0] q[$];
   logic       m_ovf = 1'b0;
   logic [7:0] sent[$];
   logic       last_strobe = 1'b0;
   logic [7:0] last_byte = '0;

   // uart_tx responder: 0 = normal (busy 2 cycles after strobe), 1 = busy held, 2 = never busy
   int mode = 0;
   int frame_len = 8;
   int dly = 0;
   int rem = 0;

   always @(negedge clk) begin
      if (mode == 1) begin
         dly = 0; rem = 0; i_tx_busy = 1'b1;
      end else if (mode == 2) begin
         dly = 0; rem = 0; i_tx_busy = 1'b0;
      end else begin
         if (dly > 0) begin
            dly--;
            if (dly == 0) rem = frame_len;
         end else if (rem > 0) begin
            rem--;
         end
         i_tx_busy = (rem > 0);
         if (o_tx_cyc && o_tx_we) begin
            if (dly > 0 || rem > 0) begin
               nerr++;
               $display("FAIL tx_overlap: strobe while frame active (dly=%0d rem=%0d)", dly, rem);
            end
            dly = 2;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // One clock: check outputs against the model, drive the next inputs, advance the model.
   task automatic step(input logic cyc, input logic we, input logic [7:0] dat);
      int sz;
      logic strobe, full;
      @(negedge clk);
      sz = q.size();
      chk("status", {24'd0, o_dat}, {24'd0, sz == DEPTH, sz == 0, m_ovf, 5'(sz)});
      if (ExpPulses == 0) chk("int_off", {31'd0, o_int}, 32'd0);
      strobe = o_tx_cyc & o_tx_we;
      last_strobe = strobe;
      if (strobe) begin
         last_byte = o_tx_dat;
         sent.push_back(o_tx_dat);
         if (sz == 0) chk("strobe_on_empty", {24'd0, o_tx_dat}, 32'hFFFF_FFFF);
         else chk("strobe_byte", {24'd0, o_tx_dat}, {24'd0, q[0]});
      end
      i_cyc = cyc;
      i_we  = we;
      i_dat = dat;
      full = (sz == DEPTH);
      if (strobe && sz > 0) void'(q.pop_front());
      if (cyc && we) begin
         if (full) m_ovf = 1'b1;
         else q.push_back(dat);
      end else if (cyc) begin
         m_ovf = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 3000) begin
         step(1'b0, 1'b0, 8'h00);
         n++;
      end
      chk("drain_done", q.size(), 0);
      repeat (40) step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 i_reset_n = 1'b0;
      i_cyc = 1'b0;
      i_we  = 1'b0;
      #1;
      chk("rst_status", {24'd0, o_dat}, 32'h40);
      chk("rst_tx_cyc", {31'd0, o_tx_cyc}, 32'd0);
      chk("rst_tx_we", {31'd0, o_tx_we}, 32'd0);
      chk("rst_tx_dat", {24'd0, o_tx_dat}, 32'd0);
      chk("rst_int", {31'd0, o_int}, 32'd0);
      q.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      #2 i_reset_n = 1'b1;
   endtask

   typedef struct {
      logic       cyc;
      logic       we;
      logic [7:0] dat;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[19];

   initial begin
      int n0, n, pulses, pulse_sent, i;
      logic [7:0] b;

      for (int k = 0; k < 16; k++) begin
         tbl[k].cyc = 1'b1;
         tbl[k].we  = 1'b1;
         tbl[k].dat = 8'(8'hC0 + k);
         tbl[k].exp = {k == 15, 1'b0, 1'b0, 5'(k + 1)};
      end
      tbl[16] = '{cyc: 1'b1, we: 1'b1, dat: 8'hEE, exp: 8'hB0};
      tbl[17] = '{cyc: 1'b1, we: 1'b0, dat: 8'h00, exp: 8'h90};
      tbl[18] = '{cyc: 1'b0, we: 1'b1, dat: 8'h77, exp: 8'h90};

      #3;
      chk("por_status", {24'd0, o_dat}, 32'h40);
      chk("por_tx_cyc", {31'd0, o_tx_cyc}, 32'd0);
      #10 i_reset_n = 1'b1;
      repeat (3) step(1'b0, 1'b0, 8'h00);

      // Single byte: strobe in the second cycle after the push edge
      step(1'b1, 1'b1, 8'hA5);
      step(1'b0, 1'b0, 8'h00);
      chk("single_no_early", {31'd0, last_strobe}, 32'd0);
      step(1'b0, 1'b0, 8'h00);
      chk("single_strobe", {31'd0, last_strobe}, 32'd1);
      chk("single_byte", {24'd0, last_byte}, 32'hA5);
      step(1'b0, 1'b0, 8'h00);
      chk("single_count0", {24'd0, o_dat}, 32'h40);
      chk("single_once", {31'd0, last_strobe}, 32'd0);
      drain();

      // Push in the ISSUE cycle with count=1
      step(1'b1, 1'b1, 8'h11);
      step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h22);
      chk("simul_issue", {31'd0, last_strobe}, 32'd1);
      step(1'b0, 1'b0, 8'h00);
      chk("simul_count", {24'd0, o_dat}, 32'h01);
      n = 0;
      do begin
         step(1'b0, 1'b0, 8'h00);
         n++;
      end while (!last_strobe && n < 60);
      chk("simul_next", {24'd0, last_byte}, 32'h22);
      drain();

      // Fill with uart_tx held busy
      mode = 1;
      for (int k = 0; k < 19; k++) begin
         step(tbl[k].cyc, tbl[k].we, tbl[k].dat);
         @(posedge clk);
         #1 chk("fill_status", {24'd0, o_dat}, {24'd0, tbl[k].exp});
      end
      mode = 0;
      drain();

      // Order and pointer wrap: 20 bytes paced below full
      n0 = sent.size();
      i = 0;
      while (i < 20) begin
         if (q.size() < DEPTH - 1) begin
            step(1'b1, 1'b1, 8'(i));
            i++;
         end else begin
            step(1'b0, 1'b0, 8'h00);
         end
      end
      drain();
      chk("order_count", sent.size() - n0, 20);
      for (int k = 0; k < 20; k++) begin
         if (n0 + k < sent.size()) chk("order_byte", {24'd0, sent[n0 + k]}, k);
      end

      // No acknowledge from uart_tx: ACK times out and the next byte still goes
      mode = 2;
      n0 = sent.size();
      step(1'b1, 1'b1, 8'h5A);
      step(1'b1, 1'b1, 8'h3C);
      n = 0;
      while (sent.size() - n0 < 2 && n < 40) begin
         step(1'b0, 1'b0, 8'h00);
         n++;
      end
      chk("timeout_sent", sent.size() - n0, 2);
      repeat (10) step(1'b0, 1'b0, 8'h00);
      mode = 0;
      drain();

      // Drained interrupt: one pulse after the second frame ends
      frame_len = 6;
      n0 = sent.size();
      pulses = 0;
      pulse_sent = 0;
      step(1'b1, 1'b1, 8'h01);
      step(1'b1, 1'b1, 8'h02);
      repeat (60) begin
         step(1'b0, 1'b0, 8'h00);
         if (o_int) begin
            pulses++;
            pulse_sent = sent.size() - n0;
         end
      end
      chk("irq_pulses", pulses, ExpPulses);
      if (ExpPulses == 1) chk("irq_after_last", pulse_sent, 2);

      // Reset mid-frame with 3 bytes still queued
      frame_len = 10;
      step(1'b1, 1'b1, 8'hD1);
      step(1'b1, 1'b1, 8'hD2);
      step(1'b1, 1'b1, 8'hD3);
      step(1'b1, 1'b1, 8'hD4);
      step(1'b0, 1'b0, 8'h00);
      chk("pre_rst_queued", q.size(), 3);
      do_reset();
      n0 = sent.size();
      repeat (40) step(1'b0, 1'b0, 8'h00);
      chk("post_rst_no_strobe", sent.size() - n0, 0);

      // Randomized traffic
      for (int c = 0; c < 1500; c++) begin
         int r;
         frame_len = $urandom_range(2, 14);
         r = $urandom % 10;
         b = 8'($urandom);
         if ($urandom % 300 == 0) begin
            do_reset();
         end else if (r < 5) begin
            step(1'b1, 1'b1, b);
         end else if (r < 7) begin
            step(1'b1, 1'b0, b);
         end else begin
            step(1'($urandom), 1'b1, b);
         end
      end
      step(1'b0, 1'b0, 8'h00);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
